alu_flag_unit: RTL and testbench
================================

Name: alu_flag_unit

Overview:
- Parametrised, registered status-flag generator for the datapath ALU result bus.
- Generalises the 8-bit combinational all-zero detector to a full flag set: zero, negative, carry, overflow and parity.
- Adds two features the combinational detector lacks:
  - sticky (accumulate) mode;
  - a saturating zero-run counter with a streak threshold flag.
- Sits after the ALU output register; feeds branch/compare logic and the status display.

Parameters:
- WIDTH, 8: result bus width; legal range ≥ 2.
- CNT_W, 4: zero-run counter width.
- RUN_TH, 3: zero_run value at or above which streak asserts; legal range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  result/carry_in/ovf_in are valid this cycle.
- result  in  WIDTH  ALU result.
- carry_in  in  1  ALU carry-out.
- ovf_in  in  1  ALU signed overflow.
- sticky  in  1  0 = snapshot mode; 1 = accumulate mode. Sampled with valid_in.
- clr  in  1  synchronous clear of flags, state and run counter.
- flags_valid  out  1  at least one result captured since reset/clr.
- zero  out  1  zero flag.
- neg  out  1  negative flag = result[WIDTH-1].
- carry  out  1  carry flag.
- ovf  out  1  overflow flag.
- parity  out  1  XOR of all result bits (1 = odd number of ones).
- zero_run  out  CNT_W  count of consecutive zero results.
- streak  out  1  zero_run >= RUN_TH.

Behaviour:
- Reset (async, rst=1): all outputs 0 immediately, independent of clk; state = EMPTY. Outputs stay 0 while rst is held.
- State machine has two states, EMPTY and LOADED.
  - flags_valid = (state == LOADED).
  - EMPTY -> LOADED on valid_in=1.
  - LOADED -> EMPTY on clr=1 && valid_in=0.
  - clr=1 && valid_in=1 (either state) -> LOADED, with the cycle's result captured as a snapshot.
- Latency: every flag is registered. A result presented on edge N is visible after edge N, i.e. one-cycle latency. With valid_in=0 all flags hold.
- Per-result terms:
  - z = (result == 0);
  - n = result[WIDTH-1];
  - p = ^result.
- Snapshot update (sticky=0, or state EMPTY, or clr=1): zero=z, neg=n, carry=carry_in, ovf=ovf_in, parity=p.
- Sticky update (sticky=1, state LOADED, clr=0):
  - zero = zero & z: stays 1 only while every result since the last load is zero;
  - neg |= n;
  - carry |= carry_in;
  - ovf |= ovf_in;
  - parity = p: parity is never sticky.
- clr=1 && valid_in=0: all flags 0, zero_run 0, state EMPTY.
- zero_run, on valid_in=1:
  - z=1 -> zero_run + 1, saturating at 2^CNT_W-1 with no wrap;
  - z=0 -> 0.
  - clr=1 && valid_in=1 -> zero_run = z ? 1 : 0.
  - zero_run is independent of sticky.
- streak is a registered output, updated in the same cycle as zero_run.
- Mode change: sticky is sampled per valid result only. Switching 1->0 takes effect on the next valid result, which is captured as a snapshot.
- Elaboration error if WIDTH < 2 or RUN_TH is out of range.

Decomposition:
- Shared package (alu_pkg) holds:
  - state typedef {EMPTY, LOADED};
  - default constants ALU_WIDTH=8, FLAG_CNT_W=4, FLAG_RUN_TH=3.
- One natural sub-module: zero_det, a parametrised reduction-NOR (WIDTH in, 1 out, purely combinational). It produces z and is instantiated once.
- Parity, saturating counter and FSM stay in alu_flag_unit. Implementation target is ~150–250 lines.

Test Plan:
- Reset: assert rst mid-cycle after loading 8'h80 -> all outputs 0 before the next edge; hold 3 cycles -> still 0, flags_valid=0.
- Snapshot: valid 8'h00 -> next cycle zero=1, parity=0, neg=0, zero_run=1. Then valid 8'h81 with carry_in=1 -> zero=0, neg=1, parity=0, carry=1, zero_run=0.
- Sticky: sticky=1; results 00, 00, 05, 00 with ovf_in=1 only on the second -> zero=1,1,0,0; ovf=0,1,1,1; parity=0,0,0,0. Then clr alone -> all 0, flags_valid=0.
- Run/saturation, CNT_W=2, RUN_TH=3: six consecutive zeros -> zero_run 1,2,3,3,3,3; streak rises with the third. Then a nonzero result -> zero_run=0, streak=0.
- Simultaneous clr+valid: sticky=1, LOADED with neg=1, carry=1; clr=1 with valid 8'h00 -> zero=1, neg=0, carry=0, zero_run=1, flags_valid=1.
- Hold: valid_in=0 for 5 cycles with result toggling randomly -> all outputs unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types and default constants for the ALU status-flag logic.
//
//   flag_state_e : EMPTY  - nothing captured since reset/clear
//                  LOADED - flag registers hold a captured result
//   ALU_WIDTH    : default result bus width
//   FLAG_CNT_W   : default zero-run counter width
//   FLAG_RUN_TH  : default zero-run streak threshold
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } flag_state_e;

  localparam int ALU_WIDTH   = 8;
  localparam int FLAG_CNT_W  = 4;
  localparam int FLAG_RUN_TH = 3;

endpackage : alu_pkg

// File: rtl/alu_flag_unit_zero_det.sv
// ---------------------------------------------------------------------------
// zero_det
//   Parametrised all-zero detector (reduction NOR), purely combinational.
//
//   Ports:
//     data  in  WIDTH  value to test
//     zero  out 1      1 when every bit of data is 0
// ---------------------------------------------------------------------------
module zero_det #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero
);

  assign zero = ~|data;

endmodule : zero_det

// File: rtl/alu_flag_unit.sv
// ---------------------------------------------------------------------------
// alu_flag_unit
//   Registered status-flag generator for the ALU result bus. Produces zero,
//   negative, carry, overflow and parity flags with one cycle of latency,
//   supports a sticky (accumulate) mode, and tracks a saturating count of
//   consecutive zero results with a streak threshold flag.
//
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      asynchronous active-high reset
//     valid_in     in   1      result/carry_in/ovf_in valid this cycle
//     result       in   WIDTH  ALU result
//     carry_in     in   1      ALU carry-out
//     ovf_in       in   1      ALU signed overflow
//     sticky       in   1      0 = snapshot, 1 = accumulate (with valid_in)
//     clr          in   1      synchronous clear of flags/state/counter
//     flags_valid  out  1      a result has been captured since reset/clr
//     zero         out  1      zero flag
//     neg          out  1      negative flag (result MSB)
//     carry        out  1      carry flag
//     ovf          out  1      overflow flag
//     parity       out  1      XOR of all result bits
//     zero_run     out  CNT_W  consecutive zero results, saturating
//     streak       out  1      zero_run >= RUN_TH
// ---------------------------------------------------------------------------
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int CNT_W  = FLAG_CNT_W,
  parameter int RUN_TH = FLAG_RUN_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             sticky,
  input  logic             clr,
  output logic             flags_valid,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             parity,
  output logic [CNT_W-1:0] zero_run,
  output logic             streak
);

  // Reject parameter sets the counter and threshold logic cannot represent.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("alu_flag_unit: WIDTH must be >= 2");
    end
    if ((CNT_W < 1) || (CNT_W > 31)) begin : g_bad_cnt_w
      $error("alu_flag_unit: CNT_W must be in 1..31");
    end else if ((RUN_TH < 1) || (RUN_TH > ((1 << CNT_W) - 1))) begin : g_bad_run_th
      $error("alu_flag_unit: RUN_TH must be in 1..2^CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RUN_THV = CNT_W'(RUN_TH);

  flag_state_e      state_q, state_d;
  logic             zero_d, neg_d, carry_d, ovf_d, parity_d, streak_d;
  logic [CNT_W-1:0] run_d;

  logic             res_zero;
  logic             res_neg;
  logic             res_parity;
  logic             take_snapshot;

  zero_det #(
    .WIDTH (WIDTH)
  ) u_zero_det (
    .data (result),
    .zero (res_zero)
  );

  assign res_neg    = result[WIDTH-1];
  assign res_parity = ^result;

  // A clear or an empty unit always restarts accumulation from this result.
  assign take_snapshot = clr || !sticky || (state_q == EMPTY);

  assign flags_valid = (state_q == LOADED);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next flag values. Without valid_in everything holds,
  // except a bare clr which empties the unit.
  always_comb begin
    state_d  = state_q;
    zero_d   = zero;
    neg_d    = neg;
    carry_d  = carry;
    ovf_d    = ovf;
    parity_d = parity;
    run_d    = zero_run;

    if (clr && !valid_in) begin
      state_d  = EMPTY;
      zero_d   = 1'b0;
      neg_d    = 1'b0;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
      parity_d = 1'b0;
      run_d    = '0;
    end else if (valid_in) begin
      state_d  = LOADED;
      parity_d = res_parity;
      if (take_snapshot) begin
        zero_d  = res_zero;
        neg_d   = res_neg;
        carry_d = carry_in;
        ovf_d   = ovf_in;
      end else begin
        zero_d  = zero & res_zero;
        neg_d   = neg | res_neg;
        carry_d = carry | carry_in;
        ovf_d   = ovf | ovf_in;
      end

      // The run counter ignores sticky; a clear restarts it from this result.
      if (!res_zero) begin
        run_d = '0;
      end else if (clr) begin
        run_d = CNT_W'(1);
      end else if (zero_run != RUN_MAX) begin
        run_d = zero_run + CNT_W'(1);
      end
    end

    streak_d = (run_d >= RUN_THV);
  end

  // Flag and counter registers; streak is registered alongside zero_run so
  // both change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero     <= 1'b0;
      neg      <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      parity   <= 1'b0;
      zero_run <= '0;
      streak   <= 1'b0;
    end else begin
      zero     <= zero_d;
      neg      <= neg_d;
      carry    <= carry_d;
      ovf      <= ovf_d;
      parity   <= parity_d;
      zero_run <= run_d;
      streak   <= streak_d;
    end
  end

endmodule : alu_flag_unit

// File: tb/tb_alu_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_unit
//   Self-checking bench for alu_flag_unit (WIDTH=8, CNT_W=2, RUN_TH=3).
//   Directed steps followed by randomized traffic, all compared against a
//   behavioural reference model of the flag rules.
// ---------------------------------------------------------------------------
module tb_alu_flag_unit;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 2;
  localparam int RUN_TH = 3;
  localparam int RUN_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic [WIDTH-1:0] result;
  logic             carry_in;
  logic             ovf_in;
  logic             sticky;
  logic             clr;
  logic             flags_valid;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             parity;
  logic [CNT_W-1:0] zero_run;
  logic             streak;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit m_loaded;
  bit m_zero, m_neg, m_carry, m_ovf, m_par;
  int m_run;

  alu_flag_unit #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .RUN_TH (RUN_TH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .result      (result),
    .carry_in    (carry_in),
    .ovf_in      (ovf_in),
    .sticky      (sticky),
    .clr         (clr),
    .flags_valid (flags_valid),
    .zero        (zero),
    .neg         (neg),
    .carry       (carry),
    .ovf         (ovf),
    .parity      (parity),
    .zero_run    (zero_run),
    .streak      (streak)
  );

  always #5 clk = ~clk;

  // Model: everything cleared.
  task automatic model_reset();
    m_loaded = 0;
    m_zero = 0; m_neg = 0; m_carry = 0; m_ovf = 0; m_par = 0;
    m_run = 0;
  endtask

  // Model: one rising edge with the given inputs.
  task automatic model_edge(input bit v, input int res, input bit c,
                            input bit o, input bit s, input bit cl);
    bit z, n, p;
    z = (res == 0);
    n = (res >= (1 << (WIDTH - 1)));
    p = ($countones(res) % 2) == 1;
    if (cl && !v) begin
      model_reset();
    end else if (v) begin
      if (cl || !s || !m_loaded) begin
        m_zero = z; m_neg = n; m_carry = c; m_ovf = o;
      end else begin
        m_zero = m_zero && z;
        m_neg  = m_neg || n;
        m_carry = m_carry || c;
        m_ovf  = m_ovf || o;
      end
      m_par = p;
      if (!z)      m_run = 0;
      else if (cl) m_run = 1;
      else         m_run = (m_run + 1 > RUN_SAT) ? RUN_SAT : m_run + 1;
      m_loaded = 1;
    end
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string tag);
    logic [8:0] obs, exp;
    obs = {flags_valid, zero, neg, carry, ovf, parity, zero_run, streak};
    exp = {m_loaded, m_zero, m_neg, m_carry, m_ovf, m_par,
           CNT_W'(m_run), (m_run >= RUN_TH)};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed fv/z/n/c/o/p/run/streak=%b expected %b",
             tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and check.
  task automatic applyStimulus(input string tag, input bit v, input int res,
                               input bit c, input bit o, input bit s,
                               input bit cl);
    @(negedge clk);
    valid_in = v;
    result   = WIDTH'(res);
    carry_in = c;
    ovf_in   = o;
    sticky   = s;
    clr      = cl;
    @(posedge clk);
    model_edge(v, res, c, o, s, cl);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; valid_in = 0; result = '0; carry_in = 0; ovf_in = 0;
    sticky = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_state");
    @(negedge clk) rst = 1'b0;

    // Asynchronous reset mid-cycle after a load.
    applyStimulus("load_80", 1, 8'h80, 1, 1, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1 checkOutput("async_reset_midcycle");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 checkOutput("reset_hold");
    end
    @(negedge clk) rst = 1'b0;

    // Snapshot mode.
    applyStimulus("snap_00", 1, 8'h00, 0, 0, 0, 0);
    applyStimulus("snap_81", 1, 8'h81, 1, 0, 0, 0);

    // Sticky accumulation after a clear.
    applyStimulus("clr_pre_sticky", 0, 8'h00, 0, 0, 1, 1);
    applyStimulus("sticky_00a", 1, 8'h00, 0, 0, 1, 0);
    applyStimulus("sticky_00b", 1, 8'h00, 0, 1, 1, 0);
    applyStimulus("sticky_05",  1, 8'h05, 0, 0, 1, 0);
    applyStimulus("sticky_00c", 1, 8'h00, 0, 0, 1, 0);
    applyStimulus("clr_alone",  0, 8'h00, 0, 0, 1, 1);

    // Zero-run saturation and streak.
    for (int i = 0; i < 6; i++)
      applyStimulus("zero_run_sat", 1, 8'h00, 0, 0, 0, 0);
    applyStimulus("zero_run_break", 1, 8'h10, 0, 0, 0, 0);

    // Simultaneous clear and valid.
    applyStimulus("load_neg_carry", 1, 8'h80, 1, 0, 1, 0);
    applyStimulus("clr_with_valid", 1, 8'h00, 0, 0, 1, 1);

    // Mode change 1->0 captures the next result as a snapshot.
    applyStimulus("sticky_neg", 1, 8'hF0, 1, 1, 1, 0);
    applyStimulus("mode_to_snap", 1, 8'h03, 0, 0, 0, 0);

    // Hold with random result toggling.
    for (int i = 0; i < 5; i++)
      applyStimulus("hold", 0, int'($urandom_range(255)), $urandom_range(1),
                    $urandom_range(1), $urandom_range(1), 0);

    // Randomized traffic, biased toward zero results to build runs.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(255));
      applyStimulus("random", $urandom_range(3) != 0, r, $urandom_range(1),
                    $urandom_range(1), $urandom_range(1),
                    $urandom_range(9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_flag_unit
